lsb_stego_wb: RTL

LSB_STEGO_WB -- requirements
Module: lsb_stego_wb

---
 rtl/lsb_stego_wb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lsb_stego_wb.sv
// LSB steganography engine: embeds/extracts a MSG_W-bit payload in pixel LSBs, XOR-whitened by a keyed LFSR.
// pix_out/pix_valid_o lag pix_in by one cycle, with no pixel backpressure; Wishbone acks one cycle after the request.
module lsb_stego_wb #(
   parameter int PIX_W = 8,
   parameter int NLSB  = 1,
   parameter int MSG_W = 32
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid_i,
   output logic [PIX_W-1:0] pix_out,
   output logic             pix_valid_o,
   output logic             busy_o,
   output logic             irq_o
);
   localparam int NPIX  = MSG_W / NLSB;
   localparam int CNT_W = $clog2(NPIX);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             mode_q, mode_d;
   logic             irq_en_q, irq_en_d;
   logic             done_q, done_d;
   logic [31:0]      key_q, key_d;
   logic [MSG_W-1:0] msg_q, msg_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [MSG_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic             pvld_q;

   logic             req, wr, busy, start, accept;
   logic [NLSB-1:0]  ks;
   logic [31:0]      rdata;
   logic             unused_adr;

   assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   always_comb begin
      req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
      wr     = req & wbs_we_i;
      busy   = (state_q != IDLE);
      start  = wr && (wbs_adr_i[3:2] == 2'd0) && wbs_sel_i[0] && wbs_dat_i[0] && !busy;
      accept = (state_q == RUN) && pix_valid_i;
      ks     = lfsr_q[NLSB-1:0];
   end

   always_comb begin
      rdata = '0;
      case (wbs_adr_i[3:2])
         2'd0:    rdata = {29'd0, irq_en_q, mode_q, 1'b0};
         2'd1:    rdata = key_q;
         2'd2:    rdata = msg_q;
         default: rdata = {30'd0, done_q, busy};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ack_d    = req;
      dat_d    = (req && !wbs_we_i) ? rdata : '0;
      mode_d   = mode_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      key_d    = key_q;
      msg_d    = msg_q;
      lfsr_d   = lfsr_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      pix_d    = pix_in;

      if (wr) begin
         case (wbs_adr_i[3:2])
            2'd0: if (wbs_sel_i[0]) begin
               irq_en_d = wbs_dat_i[2];
               if (!busy) mode_d = wbs_dat_i[1];
            end
            2'd1: if (!busy) key_d = byte_merge(key_q, wbs_dat_i, wbs_sel_i);
            2'd2: if (!busy) msg_d = byte_merge(msg_q, wbs_dat_i, wbs_sel_i);
            default: if (wbs_sel_i[0] && wbs_dat_i[1]) done_d = 1'b0;
         endcase
      end

      // FSM updates come last so setting done in DONE wins over a same-cycle clear.
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            lfsr_d  = key_q;
            shreg_d = wbs_dat_i[1] ? '0 : msg_q;
            cnt_d   = '0;
            done_d  = 1'b0;
         end
         RUN: if (accept) begin
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (mode_q) begin
               shreg_d = {pix_in[NLSB-1:0] ^ ks, shreg_q[MSG_W-1:NLSB]};
            end else begin
               pix_d   = {pix_in[PIX_W-1:NLSB], shreg_q[NLSB-1:0] ^ ks};
               shreg_d = shreg_q >> NLSB;
            end
            if (cnt_q == CNT_W'(NPIX - 1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (mode_q) msg_d = shreg_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         mode_q   <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         key_q    <= '0;
         msg_q    <= '0;
         lfsr_q   <= '0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         pix_q    <= '0;
         pvld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         mode_q   <= mode_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         key_q    <= key_d;
         msg_q    <= msg_d;
         lfsr_q   <= lfsr_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         pix_q    <= pix_d;
         pvld_q   <= pix_valid_i;
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign pix_out     = pix_q;
   assign pix_valid_o = pvld_q;
   assign busy_o      = busy;
   assign irq_o       = done_q & irq_en_q;

endmodule
